sim_ctrl: RTL
=============

SIM_CTRL -- requirements
Module: sim_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32: bus address width.
REQ-002 Parameter DATA_W, default 32: bus write-data width.
REQ-003 Parameter CNT_W, default 32: cycle and retire counter width.
REQ-004 Parameter RST_CYCLES, default 5: core-reset hold length in clk cycles after rst release; 0 is legal.
REQ-005 Parameter TIMEOUT_CYCLES, default 50000 (1 ms at 50 MHz): RUN cycles before timeout; minimum 1.
REQ-006 Parameter TOHOST_ADDR, default 32'h0000_1000: pass/fail mailbox address.
REQ-007 clk  input  1  single clock; all logic on the rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 we_i  input  1  core data-bus write strobe, one transfer per cycle.
REQ-010 addr_i  input  ADDR_W  write address.
REQ-011 wdata_i  input  DATA_W  write data.
REQ-012 retire_i  input  1  one pulse per retired instruction.
REQ-013 core_rst_o  output  1  active-high reset to the core.
REQ-014 halt_o  output  1  high in any terminal state.
REQ-015 pass_o / fail_o / timeout_o  output  1 each  terminal status flags, mutually exclusive.
REQ-016 fail_code_o  output  DATA_W  failing test number.
REQ-017 cycle_cnt_o  output  CNT_W  RUN cycles elapsed.
REQ-018 instret_o  output  CNT_W  retired-instruction count (see Configuration).

Function
REQ-019 The FSM SHALL have exactly five states: HOLD, RUN, PASS, FAIL and TIMEOUT. PASS, FAIL and TIMEOUT are terminal and sticky until rst.
REQ-020 HOLD SHALL count RST_CYCLES cycles after rst falls and then enter RUN. With RST_CYCLES=0, HOLD SHALL last exactly one cycle.
REQ-021 core_rst_o SHALL be 1 in HOLD and 0 in all other states.
REQ-022 In RUN, cycle_cnt_o SHALL increment by 1 per cycle and saturate at all-ones.
REQ-023 A RUN-cycle write with addr_i==TOHOST_ADDR and wdata_i==1 SHALL enter PASS.
REQ-024 A RUN-cycle write with addr_i==TOHOST_ADDR, wdata_i!=0 and wdata_i!=1 SHALL enter FAIL and latch fail_code_o = wdata_i>>1.
REQ-025 A mailbox write with wdata_i==0, and any write to another address, SHALL be ignored.
REQ-026 In RUN, the cycle on which cycle_cnt_o==TIMEOUT_CYCLES-1 SHALL cause entry to TIMEOUT.
REQ-027 A valid mailbox write on that same cycle SHALL take priority over the timeout.
REQ-028 Writes in HOLD or in any terminal state SHALL be ignored; fail_code_o SHALL NOT change after it is latched.
REQ-029 Latency: an event sampled on edge N SHALL be visible on the flags and halt_o after edge N, i.e. one registered stage.
REQ-030 Counters SHALL freeze in terminal states.
REQ-031 pass_o, fail_o and timeout_o SHALL each equal 1 exactly while in the matching state. halt_o SHALL equal their OR.

Reset
REQ-032 While rst=1 at a rising edge, the block SHALL enter HOLD, clear its hold counter, and set the outputs to: core_rst_o=1, halt_o=0, pass_o=0, fail_o=0, timeout_o=0, fail_code_o=0, cycle_cnt_o=0, instret_o=0.
REQ-033 rst asserted in any state, including mid-RUN or terminal, SHALL restart the full sequence from HOLD.

Configuration
REQ-034 With macro SIM_CTRL_INSTRET_EN defined:
- instret_o SHALL count retire_i pulses in RUN only, saturating.
- In RUN, each retire_i pulse SHALL also reload the timeout window, so TIMEOUT means TIMEOUT_CYCLES cycles with no retirement.
- cycle_cnt_o SHALL keep counting unaffected by the reload.
REQ-035 With SIM_CTRL_INSTRET_EN undefined:
- instret_o SHALL be constant 0 and retire_i SHALL be unused.
- Timeout SHALL depend on cycle_cnt_o only.

Verification
REQ-036 RST_CYCLES=5, rst high 3 cycles then low -> core_rst_o=1 for exactly 5 cycles after release, then 0; cycle_cnt_o starts at 0.
REQ-037 In RUN, write addr=0x1000, data=1 at cycle 20 -> pass_o=1 and halt_o=1 next cycle; cycle_cnt_o frozen at 21.
REQ-038 Write addr=0x1000, data=0x0B -> fail_o=1, fail_code_o=5. A later write of data=1 -> no change.
REQ-039 Writes of data=1 to 0x1004, and of data=0 to 0x1000 -> still RUN. TIMEOUT_CYCLES=100, no retire -> timeout_o=1 after cycle_cnt_o reaches 99.
REQ-040 TIMEOUT_CYCLES=100, mailbox write data=1 on the cycle cycle_cnt_o==99 -> pass_o=1, timeout_o=0.
REQ-041 SIM_CTRL_INSTRET_EN defined, TIMEOUT_CYCLES=100, retire_i every 50 cycles for 1000 cycles -> no timeout, instret_o=20. rst mid-RUN -> all outputs return to their reset values.

Source files
------------

// File: rtl/sim_ctrl.sv
// sim_ctrl: simulation run controller. Holds the core in reset after rst is
// released, then watches the tohost mailbox for a pass/fail report and
// raises a timeout if the test runs too long. All flags are sticky until rst.
// Optional feature macro: SIM_CTRL_INSTRET_EN (retired-instruction counter;
// each retirement also restarts the timeout window).
module sim_ctrl #(
  parameter int unsigned          ADDR_W         = 32,
  parameter int unsigned          DATA_W         = 32,
  parameter int unsigned          CNT_W          = 32,
  parameter int unsigned          RST_CYCLES     = 5,
  parameter int unsigned          TIMEOUT_CYCLES = 50000,
  parameter logic [ADDR_W-1:0]    TOHOST_ADDR    = ADDR_W'(32'h0000_1000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              retire_i,
  output logic              core_rst_o,
  output logic              halt_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              timeout_o,
  output logic [DATA_W-1:0] fail_code_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [CNT_W-1:0]  instret_o
);

  // RST_CYCLES of 0 or 1 both give a single HOLD cycle.
  localparam int unsigned HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned HOLD_LAST = (RST_CYCLES > 1) ? RST_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    HOLD,
    RUN,
    PASS,
    FAIL,
    TIMEOUT
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic [CNT_W-1:0]    cycle_cnt_q;
  logic [DATA_W-1:0]   fail_code_q;
  logic                hold_done;
  logic                mbox_hit;
  logic                mbox_pass;
  logic                tmo_hit;

  assign hold_done = (hold_cnt_q == HOLD_W'(HOLD_LAST));
  assign mbox_hit  = we_i && (addr_i == TOHOST_ADDR) && (wdata_i != '0);
  assign mbox_pass = (wdata_i == DATA_W'(1));

`ifdef SIM_CTRL_INSTRET_EN
  logic [CNT_W-1:0] win_cnt_q;
  logic [CNT_W-1:0] instret_q;

  // A retirement on the final window cycle restarts the window instead of
  // timing out.
  assign tmo_hit   = (win_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !retire_i;
  assign instret_o = instret_q;
`else
  logic unused_retire;

  assign unused_retire = retire_i;
  assign tmo_hit       = (cycle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign instret_o     = '0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a valid mailbox write outranks a same-cycle timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD: begin
        if (hold_done) state_d = RUN;
      end
      RUN: begin
        if (mbox_hit)     state_d = mbox_pass ? PASS : FAIL;
        else if (tmo_hit) state_d = TIMEOUT;
      end
      default: state_d = state_q;
    endcase
  end

  // Counters and fail-code latch; everything freezes outside HOLD/RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      fail_code_q <= '0;
`ifdef SIM_CTRL_INSTRET_EN
      win_cnt_q   <= '0;
      instret_q   <= '0;
`endif
    end else begin
      case (state_q)
        HOLD: begin
          if (!hold_done) hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
        end
        RUN: begin
          if (cycle_cnt_q != '1) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
          if (mbox_hit && !mbox_pass) fail_code_q <= wdata_i >> 1;
`ifdef SIM_CTRL_INSTRET_EN
          if (retire_i) begin
            win_cnt_q <= '0;
            if (instret_q != '1) instret_q <= instret_q + CNT_W'(1);
          end else if (win_cnt_q != '1) begin
            win_cnt_q <= win_cnt_q + CNT_W'(1);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Output decode from the registered state
  always_comb begin
    core_rst_o = 1'b0;
    pass_o     = 1'b0;
    fail_o     = 1'b0;
    timeout_o  = 1'b0;
    case (state_q)
      HOLD:    core_rst_o = 1'b1;
      PASS:    pass_o     = 1'b1;
      FAIL:    fail_o     = 1'b1;
      TIMEOUT: timeout_o  = 1'b1;
      default: ;
    endcase
    halt_o      = pass_o | fail_o | timeout_o;
    fail_code_o = fail_code_q;
    cycle_cnt_o = cycle_cnt_q;
  end

endmodule
